// File: rtl/fetch_pkg.sv
// Shared types and defaults for the ROM instruction fetch controller.
// Holds the FSM state enum, parameter defaults and the PC range check.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALT,
        ST_FAULT
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC         = 32'h0000_0000;
    localparam int unsigned DEF_ROM_DEPTH        = 256;
    localparam logic [31:0] DEF_HALT_WORD        = 32'hFFFF_FFFF;
    localparam int unsigned DEF_DBG_STARVE_LIMIT = 4;

    // True when a byte address is word aligned and inside the ROM.
    function automatic logic pc_in_rom(input logic [31:0] a,
                                       input int unsigned depth);
        logic [33:0] lim;
        lim = 34'(depth) << 2;
        return (a[1:0] == 2'b00) && ({2'b00, a} < lim);
    endfunction

endpackage

// File: rtl/rom_port_arb.sv
// ROM port arbiter: decides when the debug reader owns the shared ROM port.
// Ports: clk, reset_n, fetch_want (fetch needs ROM this cycle), dbg_req,
// rom_data in; dbg_gnt (combinational), dbg_rvalid/dbg_rdata (registered) out.
module rom_port_arb
    import fetch_pkg::*;
#(
    parameter int unsigned DBG_STARVE_LIMIT = DEF_DBG_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_want,
    input  logic        dbg_req,
    input  logic [31:0] rom_data,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata
);

    localparam int unsigned CW =
        (DBG_STARVE_LIMIT < 1) ? 1 : $clog2(DBG_STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(DBG_STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          forced;

    always_comb begin
        forced   = (starve_q >= LIM);
        // No grant in the read-return cycle: one grant per two cycles.
        dbg_gnt  = reset_n && dbg_req && !rvalid_q
                   && (!fetch_want || forced);
        starve_d = starve_q;
        if (!dbg_req || dbg_gnt) begin
            starve_d = '0;
        end else if (!forced) begin
            starve_d = starve_q + 1'b1;
        end
        rvalid_d = dbg_gnt;
        rdata_d  = dbg_gnt ? rom_data : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Sequential instruction fetch from a combinational ROM with redirect,
// halt/fault detection and a shared debug read port.
// Ports: clk, reset_n, run; rom_addr/rom_data ROM port; inst_* valid/ready
// output; redirect_*; dbg_req/addr/gnt/rvalid/rdata; halted, fault.
module rom_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC         = DEF_RESET_PC,
    parameter int unsigned ROM_DEPTH        = DEF_ROM_DEPTH,
    parameter logic [31:0] HALT_WORD        = DEF_HALT_WORD,
    parameter int unsigned DBG_STARVE_LIMIT = DEF_DBG_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        halted,
    output logic        fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  data_q, data_d;
    logic [31:0]  ipc_q, ipc_d;
    logic         halted_q, halted_d;
    logic         fault_q, fault_d;
    logic         slot_open;
    logic         fetch_want;
    logic         gnt;

    assign slot_open  = !valid_q || inst_ready;
    assign fetch_want = (state_q == ST_FETCH) && slot_open;

    rom_port_arb #(
        .DBG_STARVE_LIMIT(DBG_STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .fetch_want(fetch_want),
        .dbg_req   (dbg_req),
        .rom_data  (rom_data),
        .dbg_gnt   (gnt),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata (dbg_rdata)
    );

    assign rom_addr = gnt ? dbg_addr : pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        data_d   = data_q;
        ipc_d    = ipc_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    // Redirect wins even over a forced debug grant.
                    valid_d = 1'b0;
                    if (pc_in_rom(redirect_pc, ROM_DEPTH)) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end
                end else if (slot_open) begin
                    valid_d = 1'b0;
                    if (!gnt) begin
                        if (!pc_in_rom(pc_q, ROM_DEPTH)) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end else if (rom_data == HALT_WORD) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = rom_data;
                            ipc_d   = pc_q;
                            pc_d    = pc_q + 32'd4;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            data_q   <= 32'h0;
            ipc_q    <= 32'h0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ipc_q    <= ipc_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign dbg_gnt    = gnt;
    assign inst_valid = valid_q;
    assign inst_data  = data_q;
    assign inst_pc    = ipc_q;
    assign halted     = halted_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: vector table, directed corner
// sequences and a randomized run checked against a stream-level model.
module tb_rom_fetch_ctrl;

    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_SUB = 32'h403100B3;
    localparam logic [31:0] I_AND = 32'h003170B3;
    localparam logic [31:0] I_OR  = 32'h003160B3;
    localparam logic [31:0] I_NOP = 32'h00000013;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        halted;
    logic        fault;

    logic [31:0] rom [0:255];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rom_data = (rom_addr < 32'd1024) ? rom[rom_addr[9:2]] : 32'h0;

    rom_fetch_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run           (run),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dbg_req       (dbg_req),
        .dbg_addr      (dbg_addr),
        .dbg_gnt       (dbg_gnt),
        .dbg_rvalid    (dbg_rvalid),
        .dbg_rdata     (dbg_rdata),
        .halted        (halted),
        .fault         (fault)
    );

    typedef struct {
        bit          run;
        bit          ready;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] edata;
        bit          ehalt;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n        = 1'b0;
        run            = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dbg_req        = 1'b0;
        dbg_addr       = 32'h0;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    task automatic start;
        run = 1'b1;
        tick;
        run = 1'b0;
    endtask

    // Leaves the bench at the negedge of the cycle where pc is presented.
    task automatic wait_pc(input logic [31:0] pc, input int lim);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (inst_valid && inst_pc == pc) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_pc: pc %h not seen in %0d cycles", pc, lim);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        logic [31:0] exp_pc;
        logic [31:0] rv_exp;
        bit          rv_pend;
        int          w;
        int          wait_c;

        vt[0] = '{0, 1, 0, 32'd0,  32'h0, 0};
        vt[1] = '{1, 1, 0, 32'd0,  32'h0, 0};
        vt[2] = '{0, 1, 0, 32'd0,  32'h0, 0};
        vt[3] = '{0, 1, 1, 32'd0,  I_ADD, 0};
        vt[4] = '{0, 1, 1, 32'd4,  I_SUB, 0};
        vt[5] = '{0, 1, 1, 32'd8,  I_AND, 0};
        vt[6] = '{0, 1, 1, 32'd12, I_OR,  0};
        vt[7] = '{0, 1, 1, 32'd16, I_NOP, 0};
        vt[8] = '{0, 1, 0, 32'd0,  32'h0, 1};
        vt[9] = '{0, 1, 0, 32'd0,  32'h0, 1};

        for (int i = 0; i < 256; i++) rom[i] = I_NOP + (32'(i) << 7);
        rom[0] = I_ADD;
        rom[1] = I_SUB;
        rom[2] = I_AND;
        rom[3] = I_OR;
        rom[4] = I_NOP;
        rom[5] = HALTW;

        // Reset state
        do_reset;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_rvalid", 32'(dbg_rvalid), 0);
        chk("rst_romaddr", rom_addr, 32'h0);
        tick;
        reset_n = 1'b1;

        // Basic stream into halt
        for (int i = 0; i < 10; i++) begin
            run        = vt[i].run;
            inst_ready = vt[i].ready;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vt[i].ev));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_pc", i), inst_pc, vt[i].epc);
                chk($sformatf("vec%0d_data", i), inst_data, vt[i].edata);
            end
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(vt[i].ehalt));
            tick;
        end

        // Debug read while halted
        dbg_req  = 1'b1;
        dbg_addr = 32'h8;
        @(negedge clk);
        chk("halt_dbg_gnt", 32'(dbg_gnt), 1);
        tick;
        dbg_req = 1'b0;
        @(negedge clk);
        chk("halt_dbg_rvalid", 32'(dbg_rvalid), 1);
        chk("halt_dbg_rdata", dbg_rdata, I_AND);
        chk("halt_valid", 32'(inst_valid), 0);
        tick;
        rom[5] = I_NOP;

        // Stall with debug read in the stall
        do_reset;
        inst_ready = 1'b1;
        start;
        wait_pc(32'h8, 20);
        inst_ready = 1'b0;
        dbg_req    = 1'b1;
        dbg_addr   = 32'h4;
        #1;
        chk("stall_gnt", 32'(dbg_gnt), 1);
        tick;
        dbg_req = 1'b0;
        @(negedge clk);
        chk("stall_rvalid", 32'(dbg_rvalid), 1);
        chk("stall_rdata", dbg_rdata, I_SUB);
        chk("stall_pc1", inst_pc, 32'h8);
        tick;
        @(negedge clk);
        chk("stall_pc2", inst_pc, 32'h8);
        chk("stall_valid2", 32'(inst_valid), 1);
        tick;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("stall_pc3", inst_pc, 32'h8);
        tick;
        @(negedge clk);
        chk("stall_next_pc", inst_pc, 32'hC);
        tick;

        // Redirect, then misaligned redirect
        do_reset;
        inst_ready = 1'b1;
        start;
        wait_pc(32'h10, 20);
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h70;
        tick;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        @(negedge clk);
        chk("redir_drop", 32'(inst_valid), 0);
        tick;
        @(negedge clk);
        chk("redir_valid", 32'(inst_valid), 1);
        chk("redir_pc", inst_pc, 32'h70);
        chk("redir_data", inst_data, rom[28]);
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h72;
        tick;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("mis_fault", 32'(fault), 1);
        chk("mis_valid", 32'(inst_valid), 0);
        tick;

        // Out of range redirect
        do_reset;
        start;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        tick;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("oor_fault", 32'(fault), 1);
        tick;

        // Sequential run off the end of the ROM
        do_reset;
        inst_ready = 1'b1;
        start;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3F8;
        tick;
        redirect_valid = 1'b0;
        wait_pc(32'h3FC, 10);
        chk("end_fault_pre", 32'(fault), 0);
        tick;
        @(negedge clk);
        chk("end_fault", 32'(fault), 1);
        chk("end_valid", 32'(inst_valid), 0);
        tick;

        // Debug starvation under continuous fetch
        do_reset;
        inst_ready = 1'b1;
        start;
        wait_pc(32'h8, 20);
        dbg_req  = 1'b1;
        dbg_addr = 32'h14;
        w = 0;
        for (int i = 0; i < 10; i++) begin
            if (dbg_gnt) break;
            w++;
            tick;
            @(negedge clk);
        end
        chk("starve_wait", 32'(w), 32'd4);
        p = inst_pc;
        tick;
        dbg_req = 1'b0;
        @(negedge clk);
        chk("starve_rvalid", 32'(dbg_rvalid), 1);
        chk("starve_rdata", dbg_rdata, rom[5]);
        chk("starve_bubble", 32'(inst_valid), 0);
        tick;
        @(negedge clk);
        chk("starve_resume", inst_pc, p + 32'd4);
        tick;

        // Reset in the middle of fetch
        do_reset;
        inst_ready = 1'b1;
        start;
        wait_pc(32'h8, 20);
        inst_ready = 1'b0;
        dbg_req    = 1'b1;
        dbg_addr   = 32'h0;
        tick;
        dbg_req = 1'b0;
        tick;
        reset_n = 1'b0;
        tick;
        @(negedge clk);
        chk("mrst_valid", 32'(inst_valid), 0);
        chk("mrst_data", inst_data, 32'h0);
        chk("mrst_pc", inst_pc, 32'h0);
        chk("mrst_gnt", 32'(dbg_gnt), 0);
        chk("mrst_rvalid", 32'(dbg_rvalid), 0);
        chk("mrst_rdata", dbg_rdata, 32'h0);
        chk("mrst_romaddr", rom_addr, 32'h0);
        tick;
        reset_n    = 1'b1;
        inst_ready = 1'b1;
        start;
        tick;
        @(negedge clk);
        chk("mrst_restart_pc", inst_pc, 32'h0);
        chk("mrst_restart_data", inst_data, I_ADD);
        tick;

        // Randomized stream against an in-order PC model
        do_reset;
        for (int i = 0; i < 256; i++) begin
            rom[i] = $urandom;
            if (rom[i] == HALTW) rom[i] = 32'h0;
        end
        start;
        exp_pc  = 32'h0;
        rv_pend = 1'b0;
        rv_exp  = 32'h0;
        wait_c  = 0;
        for (int c = 0; c < 3000; c++) begin
            redirect_valid = 1'b0;
            if (exp_pc >= 32'h3C0 || $urandom_range(0, 19) == 0) begin
                inst_ready     = 1'b0;
                redirect_valid = 1'b1;
                redirect_pc    = 32'($urandom_range(0, 200)) << 2;
            end else begin
                inst_ready = ($urandom_range(0, 3) != 0);
            end
            if (!dbg_req && !rv_pend && $urandom_range(0, 7) == 0) begin
                dbg_req  = 1'b1;
                dbg_addr = 32'($urandom_range(0, 255)) << 2;
                wait_c   = 0;
            end
            @(negedge clk);
            if (rv_pend) begin
                chk("rnd_rvalid", 32'(dbg_rvalid), 1);
                chk("rnd_rdata", dbg_rdata, rv_exp);
                rv_pend = 1'b0;
            end
            if (inst_valid && inst_ready) begin
                chk("rnd_pc", inst_pc, exp_pc);
                chk("rnd_data", inst_data, rom[exp_pc[9:2]]);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            if (dbg_req) begin
                if (dbg_gnt) begin
                    chk("rnd_starve_bound", 32'(wait_c <= 4), 1);
                    rv_exp  = rom[dbg_addr[9:2]];
                    rv_pend = 1'b1;
                end else begin
                    wait_c++;
                end
            end
            tick;
            if (rv_pend) dbg_req = 1'b0;
        end
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rnd_fault", 32'(fault), 0);
        chk("rnd_halted", 32'(halted), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
